alu_pipe: RTL and testbench
===========================

ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits; legal range 4..32.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: in_valid  input  1  operation request valid.
REQ-005 Port: in_ready  output  1  block can accept a request this cycle.
REQ-006 Port: A, B  input  WIDTH each  operands.
REQ-007 Port: opcode  input  4  operation select.
REQ-008 Port: out_valid  output  1  result/flags valid.
REQ-009 Port: out_ready  input  1  consumer accepts the result.
REQ-010 Port: result  output  WIDTH  registered result.
REQ-011 Port: flags  output  4  registered {N,Z,C,V}.
REQ-012 Port: err  output  1  registered illegal-opcode indicator.

Function
REQ-013 A request SHALL be accepted on a rising edge with in_valid && in_ready; A, B and opcode are captured at that edge.
REQ-014 Opcodes SHALL be: 0 ADD, 1 SUB (A-B), 2 AND, 3 OR, 4 XOR, 5 NOR, 6 NAND, 7 PASS A, 8 SHL, 9 SHR logical, 10 SRA, 11 SLT signed, 12 SLTU, 13/14 reserved, 15 MUL.
REQ-015 Shift amount SHALL be B[clog2(WIDTH)-1:0]; an amount of 0 returns A.
REQ-016 SLT/SLTU SHALL return 1 (zero-extended to WIDTH) when A<B, else 0.
REQ-017 ADD SHALL set C=carry-out and V=signed overflow; SUB SHALL set C=borrow (A<B unsigned) and V=signed overflow; all other ops SHALL set C=0 and V=0 except MUL (REQ-022).
REQ-018 Every op SHALL set Z=(result==0) and N=result[WIDTH-1].
REQ-019 Reserved opcodes SHALL produce result=0, flags=4'b0100 and err=1; legal opcodes SHALL produce err=0.
REQ-020 Opcodes 0-14 SHALL have latency 1: out_valid rises on the edge following acceptance.
REQ-021 State machine SHALL have states IDLE (output register empty), MUL (iterating), HOLD (output register full, awaiting out_ready).
REQ-022 MUL SHALL be iterative shift-add, one bit per cycle, WIDTH cycles in MUL, then HOLD; result = low WIDTH bits of product, C = (upper WIDTH bits != 0), V=0.
REQ-023 in_ready SHALL be 1 in IDLE, 0 in MUL, and equal to out_ready in HOLD.
REQ-024 Transitions: IDLE -accept non-MUL-> HOLD; IDLE -accept MUL-> MUL; MUL -count done-> HOLD; HOLD -out_ready && no accept-> IDLE; HOLD -out_ready && accept-> HOLD (non-MUL) or MUL (MUL).
REQ-025 While out_valid=1 and out_ready=0, result, flags and err SHALL remain stable.
REQ-026 Back-to-back single-cycle ops with out_ready held high SHALL sustain one result per cycle.
REQ-027 out_valid SHALL be 1 exactly in HOLD.

Reset
REQ-028 rst_n low SHALL immediately force state IDLE, out_valid=0, result=0, flags=0, err=0, MUL counter/accumulator cleared.
REQ-029 Reset asserted during MUL or HOLD SHALL discard the operation; in_ready=1 on the first edge after rst_n rises.

Configuration
REQ-030 Macro ALU_PIPE_MUL_EN defined: opcode 15 SHALL behave per REQ-022.
REQ-031 Macro ALU_PIPE_MUL_EN undefined: opcode 15 SHALL be treated as reserved (REQ-019, latency 1), MUL state and multiplier logic SHALL not be synthesised.

Verification
REQ-032 WIDTH=8, ADD A=0xFF B=0x01 -> next cycle out_valid=1, result=0x00, flags N=0 Z=1 C=1 V=0.
REQ-033 SUB A=0x80 B=0x01 -> result=0x7F, N=0 Z=0 C=0 V=1; SLT A=0x80 B=0x01 -> result=0x01.
REQ-034 Issue ADD with out_ready=0 for 3 cycles -> out_valid=1, in_ready=0, result stable; raise out_ready with new XOR request -> both handshakes complete same edge, XOR result next cycle.
REQ-035 MUL_EN defined: MUL 0x0F*0x11 -> out_valid after 9 edges, result=0xFF, C=0; MUL 0x10*0x10 -> result=0x00, Z=1, C=1.
REQ-036 Assert rst_n low 3 cycles into a MUL -> out_valid=0, all outputs 0 immediately; in_ready=1 after release.
REQ-037 opcode 14 (and 15 without MUL_EN), A=0x55 -> result=0x00, err=1, Z=1, latency 1.

Source files
------------

// File: rtl/alu_pipe.sv
// Pipelined ALU: single-cycle logic/arithmetic ops with a one-deep output register.
// Define ALU_PIPE_MUL_EN to enable the iterative shift-add multiplier on opcode 15.
module alu_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             err
);

  localparam int SW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NOR  = 4'd5;
  localparam logic [3:0] OP_NAND = 4'd6;
  localparam logic [3:0] OP_PASS = 4'd7;
  localparam logic [3:0] OP_SHL  = 4'd8;
  localparam logic [3:0] OP_SHR  = 4'd9;
  localparam logic [3:0] OP_SRA  = 4'd10;
  localparam logic [3:0] OP_SLT  = 4'd11;
  localparam logic [3:0] OP_SLTU = 4'd12;
`ifdef ALU_PIPE_MUL_EN
  localparam logic [3:0] OP_MUL  = 4'd15;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
`ifdef ALU_PIPE_MUL_EN
    ST_MUL  = 2'd1,
`endif
    ST_HOLD = 2'd2
  } state_t;

  state_t             state_r;
  logic [WIDTH-1:0]   result_r;
  logic [3:0]         flags_r;
  logic               err_r;

  logic [WIDTH:0]     sum_s;
  logic [WIDTH:0]     diff_s;
  logic [SW-1:0]      shamt_s;
  logic [WIDTH-1:0]   alu_res_s;
  logic               alu_c_s;
  logic               alu_v_s;
  logic               alu_err_s;
  logic               accept_s;

`ifdef ALU_PIPE_MUL_EN
  logic [2*WIDTH-1:0] mcand_r;
  logic [WIDTH-1:0]   mplier_r;
  logic [2*WIDTH-1:0] acc_r;
  logic [CW-1:0]      cnt_r;
  logic [2*WIDTH-1:0] prod_s;
`endif

  // Flags are packed {N,Z,C,V}; N and Z always follow the result value.
  function automatic logic [3:0] pack_flags(input logic [WIDTH-1:0] r,
                                            input logic c,
                                            input logic v);
    return {r[WIDTH-1], (r == {WIDTH{1'b0}}), c, v};
  endfunction

  // Handshake readiness: HOLD can take a new request only while the result drains.
  always_comb begin
    in_ready = 1'b0;
    case (state_r)
      ST_IDLE: in_ready = 1'b1;
      ST_HOLD: in_ready = out_ready;
      default: in_ready = 1'b0;
    endcase
  end

  assign accept_s = in_valid && in_ready;

  // Single-cycle datapath evaluated directly on the request inputs.
  always_comb begin
    sum_s     = {1'b0, A} + {1'b0, B};
    diff_s    = {1'b0, A} - {1'b0, B};
    shamt_s   = B[SW-1:0];
    alu_res_s = {WIDTH{1'b0}};
    alu_c_s   = 1'b0;
    alu_v_s   = 1'b0;
    alu_err_s = 1'b0;
    case (opcode)
      OP_ADD: begin
        alu_res_s = sum_s[WIDTH-1:0];
        alu_c_s   = sum_s[WIDTH];
        alu_v_s   = (A[WIDTH-1] == B[WIDTH-1]) && (sum_s[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        // diff_s[WIDTH] is the borrow, i.e. A < B unsigned.
        alu_res_s = diff_s[WIDTH-1:0];
        alu_c_s   = diff_s[WIDTH];
        alu_v_s   = (A[WIDTH-1] != B[WIDTH-1]) && (diff_s[WIDTH-1] != A[WIDTH-1]);
      end
      OP_AND:  alu_res_s = A & B;
      OP_OR:   alu_res_s = A | B;
      OP_XOR:  alu_res_s = A ^ B;
      OP_NOR:  alu_res_s = ~(A | B);
      OP_NAND: alu_res_s = ~(A & B);
      OP_PASS: alu_res_s = A;
      OP_SHL:  alu_res_s = A << shamt_s;
      OP_SHR:  alu_res_s = A >> shamt_s;
      OP_SRA:  alu_res_s = WIDTH'($signed(A) >>> shamt_s);
      OP_SLT:  alu_res_s = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_SLTU: alu_res_s = {{(WIDTH-1){1'b0}}, (A < B)};
`ifdef ALU_PIPE_MUL_EN
      OP_MUL:  alu_res_s = {WIDTH{1'b0}};
`endif
      default: alu_err_s = 1'b1;
    endcase
  end

`ifdef ALU_PIPE_MUL_EN
  assign prod_s = acc_r + (mplier_r[0] ? mcand_r : {(2*WIDTH){1'b0}});
`endif

  // Control FSM and output/multiplier registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      result_r <= {WIDTH{1'b0}};
      flags_r  <= 4'd0;
      err_r    <= 1'b0;
`ifdef ALU_PIPE_MUL_EN
      mcand_r  <= {(2*WIDTH){1'b0}};
      mplier_r <= {WIDTH{1'b0}};
      acc_r    <= {(2*WIDTH){1'b0}};
      cnt_r    <= {CW{1'b0}};
`endif
    end else begin
      case (state_r)
        ST_IDLE, ST_HOLD: begin
          if (accept_s) begin
`ifdef ALU_PIPE_MUL_EN
            if (opcode == OP_MUL) begin
              state_r  <= ST_MUL;
              mcand_r  <= {{WIDTH{1'b0}}, A};
              mplier_r <= B;
              acc_r    <= {(2*WIDTH){1'b0}};
              cnt_r    <= {CW{1'b0}};
            end else
`endif
            begin
              state_r  <= ST_HOLD;
              result_r <= alu_res_s;
              flags_r  <= pack_flags(alu_res_s, alu_c_s, alu_v_s);
              err_r    <= alu_err_s;
            end
          end else if ((state_r == ST_HOLD) && out_ready) begin
            state_r <= ST_IDLE;
          end else begin
            state_r <= state_r;
          end
        end
`ifdef ALU_PIPE_MUL_EN
        ST_MUL: begin
          // One multiplier bit per cycle; the last step lands straight in HOLD.
          acc_r    <= prod_s;
          mcand_r  <= {mcand_r[2*WIDTH-2:0], 1'b0};
          mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
          cnt_r    <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
          if (cnt_r == CNT_LAST) begin
            state_r  <= ST_HOLD;
            result_r <= prod_s[WIDTH-1:0];
            flags_r  <= pack_flags(prod_s[WIDTH-1:0],
                                   (prod_s[2*WIDTH-1:WIDTH] != {WIDTH{1'b0}}), 1'b0);
            err_r    <= 1'b0;
          end else begin
            state_r <= ST_MUL;
          end
        end
`endif
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  assign out_valid = (state_r == ST_HOLD);
  assign result    = result_r;
  assign flags     = flags_r;
  assign err       = err_r;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed self-checking bench for alu_pipe (WIDTH=8); MUL checks follow ALU_PIPE_MUL_EN.
module tb_alu_pipe;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [3:0]   opcode;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic [3:0]   flags;
  logic         err;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic [W-1:0] r;
    logic [3:0]   f;
    logic         e;
  } vec_t;

  vec_t vecs [21];

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (a),
    .B         (b),
    .opcode    (opcode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags),
    .err       (err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present one request at a falling edge; it is taken on the following rising edge.
  task automatic issue(input logic [3:0] op, input logic [W-1:0] av, input logic [W-1:0] bv);
    in_valid = 1'b1;
    opcode   = op;
    a        = av;
    b        = bv;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

`ifdef ALU_PIPE_MUL_EN
  task automatic mul_run(input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic [W-1:0] er, input logic [3:0] ef);
    int n;
    n = 0;
    in_valid = 1'b1;
    opcode   = 4'd15;
    a        = av;
    b        = bv;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        in_valid = 1'b0;
        check_eq("mul_in_ready_busy", {31'd0, in_ready}, 32'd0);
      end
    end while (!out_valid && n < 40);
    check_eq("mul_latency", n, 32'd9);
    check_eq("mul_result", {24'd0, result}, {24'd0, er});
    check_eq("mul_flags", {28'd0, flags}, {28'd0, ef});
    check_eq("mul_err", {31'd0, err}, 32'd0);
    @(negedge clk);
  endtask
`endif

  initial begin
    vecs = '{
      '{4'd0,  8'hFF, 8'h01, 8'h00, 4'b0110, 1'b0},
      '{4'd1,  8'h80, 8'h01, 8'h7F, 4'b0001, 1'b0},
      '{4'd11, 8'h80, 8'h01, 8'h01, 4'b0000, 1'b0},
      '{4'd12, 8'h80, 8'h01, 8'h00, 4'b0100, 1'b0},
      '{4'd11, 8'h01, 8'h80, 8'h00, 4'b0100, 1'b0},
      '{4'd12, 8'h01, 8'h80, 8'h01, 4'b0000, 1'b0},
      '{4'd1,  8'h01, 8'h02, 8'hFF, 4'b1010, 1'b0},
      '{4'd0,  8'h7F, 8'h01, 8'h80, 4'b1001, 1'b0},
      '{4'd2,  8'hF0, 8'h3C, 8'h30, 4'b0000, 1'b0},
      '{4'd3,  8'hF0, 8'h0F, 8'hFF, 4'b1000, 1'b0},
      '{4'd4,  8'hAA, 8'hFF, 8'h55, 4'b0000, 1'b0},
      '{4'd5,  8'h0F, 8'hF0, 8'h00, 4'b0100, 1'b0},
      '{4'd6,  8'hFF, 8'hFF, 8'h00, 4'b0100, 1'b0},
      '{4'd7,  8'h55, 8'hAA, 8'h55, 4'b0000, 1'b0},
      '{4'd8,  8'h81, 8'h01, 8'h02, 4'b0000, 1'b0},
      '{4'd8,  8'h81, 8'h08, 8'h81, 4'b1000, 1'b0},
      '{4'd9,  8'h81, 8'h07, 8'h01, 4'b0000, 1'b0},
      '{4'd10, 8'h81, 8'h07, 8'hFF, 4'b1000, 1'b0},
      '{4'd10, 8'h81, 8'h01, 8'hC0, 4'b1000, 1'b0},
      '{4'd13, 8'h55, 8'h00, 8'h00, 4'b0100, 1'b1},
      '{4'd14, 8'h55, 8'h00, 8'h00, 4'b0100, 1'b1}
    };

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = 8'h00;
    b         = 8'h00;
    opcode    = 4'd0;
    #1;
    check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_result", {24'd0, result}, 32'd0);
    check_eq("rst_flags", {28'd0, flags}, 32'd0);
    check_eq("rst_err", {31'd0, err}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("idle_in_ready", {31'd0, in_ready}, 32'd1);

    // Directed single-cycle vectors, one request at a time.
    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].va, vecs[i].vb);
      check_eq($sformatf("vec%0d_valid", i), {31'd0, out_valid}, 32'd1);
      check_eq($sformatf("vec%0d_result", i), {24'd0, result}, {24'd0, vecs[i].r});
      check_eq($sformatf("vec%0d_flags", i), {28'd0, flags}, {28'd0, vecs[i].f});
      check_eq($sformatf("vec%0d_err", i), {31'd0, err}, {31'd0, vecs[i].e});
    end
    @(negedge clk);
    check_eq("drain_out_valid", {31'd0, out_valid}, 32'd0);

`ifndef ALU_PIPE_MUL_EN
    issue(4'd15, 8'h55, 8'h00);
    check_eq("op15_valid", {31'd0, out_valid}, 32'd1);
    check_eq("op15_result", {24'd0, result}, 32'd0);
    check_eq("op15_flags", {28'd0, flags}, 32'h4);
    check_eq("op15_err", {31'd0, err}, 32'd1);
    @(negedge clk);
`endif

    // Back-to-back: one result per cycle with out_ready high.
    in_valid = 1'b1; opcode = 4'd0; a = 8'h10; b = 8'h20;
    @(negedge clk);
    check_eq("b2b0_result", {24'd0, result}, 32'h30);
    check_eq("b2b0_ready", {31'd0, in_ready}, 32'd1);
    opcode = 4'd1; a = 8'h05; b = 8'h05;
    @(negedge clk);
    check_eq("b2b1_result", {24'd0, result}, 32'h00);
    check_eq("b2b1_flags", {28'd0, flags}, 32'h4);
    opcode = 4'd4; a = 8'h0F; b = 8'hF0;
    @(negedge clk);
    check_eq("b2b2_result", {24'd0, result}, 32'hFF);
    check_eq("b2b2_valid", {31'd0, out_valid}, 32'd1);
    in_valid = 1'b0;
    @(negedge clk);
    check_eq("b2b_done_valid", {31'd0, out_valid}, 32'd0);

    // Stall: result held while out_ready is low, then concurrent handshakes.
    out_ready = 1'b0;
    issue(4'd0, 8'h03, 8'h04);
    for (int k = 0; k < 3; k++) begin
      check_eq($sformatf("stall%0d_valid", k), {31'd0, out_valid}, 32'd1);
      check_eq($sformatf("stall%0d_ready", k), {31'd0, in_ready}, 32'd0);
      check_eq($sformatf("stall%0d_result", k), {24'd0, result}, 32'h07);
      @(negedge clk);
    end
    out_ready = 1'b1;
    in_valid  = 1'b1; opcode = 4'd4; a = 8'h0F; b = 8'hFF;
    #1;
    check_eq("stall_release_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check_eq("stall_xor_valid", {31'd0, out_valid}, 32'd1);
    check_eq("stall_xor_result", {24'd0, result}, 32'hF0);
    check_eq("stall_xor_flags", {28'd0, flags}, 32'h8);
    @(negedge clk);
    check_eq("stall_drain_valid", {31'd0, out_valid}, 32'd0);

`ifdef ALU_PIPE_MUL_EN
    mul_run(8'h0F, 8'h11, 8'hFF, 4'b1000);
    mul_run(8'h10, 8'h10, 8'h00, 4'b0110);
    mul_run(8'h03, 8'h05, 8'h0F, 4'b0000);

    // Reset three cycles into a multiply.
    in_valid = 1'b1; opcode = 4'd15; a = 8'h0F; b = 8'h11;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("rstmul_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rstmul_result", {24'd0, result}, 32'd0);
    check_eq("rstmul_flags", {28'd0, flags}, 32'd0);
    check_eq("rstmul_err", {31'd0, err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rstmul_in_ready", {31'd0, in_ready}, 32'd1);
    check_eq("rstmul_idle_valid", {31'd0, out_valid}, 32'd0);
`endif

    // Reset while holding an unconsumed result.
    out_ready = 1'b0;
    issue(4'd14, 8'h55, 8'h00);
    check_eq("rsthold_pre_err", {31'd0, err}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("rsthold_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rsthold_flags", {28'd0, flags}, 32'd0);
    check_eq("rsthold_err", {31'd0, err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check_eq("rsthold_in_ready", {31'd0, in_ready}, 32'd1);
    issue(4'd0, 8'h01, 8'h01);
    check_eq("recover_result", {24'd0, result}, 32'h02);
    check_eq("recover_valid", {31'd0, out_valid}, 32'd1);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
